// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM state
// encoding and the frame geometry (length prefix size, bytes per word).
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; the 4th byte is passed
// straight through as the MSB so the word is available in the same cycle.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0] idx;
    logic [23:0]      shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (byte_valid) begin
            idx <= idx + 1'b1;
        end
    end

    // Byte lane contents are only meaningful once idx says so; no reset needed.
    always_ff @(posedge clk) begin
        if (byte_valid) begin
            shift <= {byte_in, shift[23:8]};
        end
    end

    assign word       = {byte_in, shift};
    assign word_valid = byte_valid && (idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the CPU instruction memory; holds the CPU in
// reset until a complete image is written. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic        xfer;
    logic        data_xfer;
    logic        clr;
    logic        last_word;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_in;
    logic [15:0] word_cnt;
    logic [31:0] pk_word;
    logic        pk_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    assign in_ready  = (state == LEN0) || (state == LEN1) ||
                       (state == DATA) || (state == CHK);
    assign xfer      = in_valid && in_ready;
    assign data_xfer = xfer && (state == DATA);
    assign len_in    = {in_data, len_lo};
    assign last_word = pk_valid && (word_cnt == len - 16'd1);
    assign done      = (state == DONE);
    assign error     = (state == ERR);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_valid (data_xfer),
        .byte_in    (in_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_comb begin
        state_next = state;
        clr        = 1'b0;
        case (state)
            LEN0: begin
                if (xfer) state_next = LEN1;
            end
            LEN1: begin
                if (xfer) begin
                    if (len_in == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end else if ({1'b0, len_in} > MAX_LEN) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) state_next = (in_data == chk) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start) begin
                    state_next = LEN0;
                    clr        = 1'b1;
                end
            end
            default: state_next = LEN0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LEN0;
        end else begin
            state <= state_next;
        end
    end

    // Write port and counters; the write lands one cycle after the 4th byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo    <= '0;
            len       <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
        end else begin
            mem_we   <= pk_valid;
            // Release the CPU only once DONE has been held for a cycle.
            cpu_hold <= (state != DONE) || start;
            if (state == LEN0 && xfer) len_lo <= in_data;
            if (state == LEN1 && xfer) len    <= len_in;
            if (pk_valid) begin
                mem_wdata <= pk_word;
                mem_addr  <= word_cnt[ADDR_W-1:0];
                word_cnt  <= word_cnt + 16'd1;
            end
            if (clr) word_cnt <= '0;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk <= '0;
        end else if (clr) begin
            chk <= '0;
        end else if (data_xfer) begin
            chk <= chk ^ in_data;
        end
    end
`endif

endmodule
